sm4_encryptor_host: RTL and testbench
=====================================

SM4_ENCRYPTOR_HOST -- requirements
Module: sm4_encryptor_host

Interface
REQ-001 SHALL have parameter BYTE_SWAP, default 0; when 1, each 32-bit word is byte-reversed at both host input and host output.
REQ-002 SHALL have clk_i, input, 1: the single clock; all state is rising-edge.
REQ-003 SHALL have reset_i, input, 1: reset, asynchronous, active-low.
REQ-004 SHALL have word_i, input, 32: host plaintext or ciphertext word. The first word carries bits [127:96].
REQ-005 SHALL have word_v_i / word_ready_o, in/out, 1/1: host input handshake.
REQ-006 SHALL have mode_i, input, 1: 1 = encrypt, 0 = decrypt; sampled with the first word of a block.
REQ-007 SHALL have key_i / key_load_i, input, 128/1: key value and its load strobe.
REQ-008 SHALL have iv_i / iv_load_i, input, 128/1: CBC initial vector and its load strobe.
REQ-009 SHALL have content_o, key_o, encode_or_decode_o, v_o, output, 128/128/1/1: engine request. Transfers when v_o & ready_i.
REQ-010 SHALL have ready_i, input, 1: engine can accept a request.
REQ-011 SHALL have crypt_i / v_i, input, 128/1: engine result.
REQ-012 SHALL have yumi_o, output, 1: result consumed.
REQ-013 SHALL have invalid_cache_o, output, 1: one-cycle pulse that flushes the engine's round-key cache.
REQ-014 SHALL have word_o / word_v_o, output, 32/1, and word_yumi_i, input, 1: host result words, valid-yumi handshake.

Function
REQ-015 SHALL run FSM GATHER -> ISSUE -> WAIT -> DRAIN -> GATHER, with exactly one block in flight.
REQ-016 GATHER SHALL drive word_ready_o=1 and shift in one word per word_v_i & word_ready_o; a 2-bit count moves to ISSUE on the 4th word.
REQ-017 ISSUE SHALL hold v_o=1, with content_o/key_o/encode_or_decode_o stable, until ready_i; it then enters WAIT the next cycle.
REQ-018 WAIT SHALL drive yumi_o = v_i combinationally, latch crypt_i on that cycle, and enter DRAIN.
REQ-019 DRAIN SHALL drive word_v_o=1 and present words MSW first; word_o SHALL hold until word_yumi_i; after the 4th yumi it returns to GATHER with count 0.
REQ-020 word_yumi_i without word_v_o, and v_i outside WAIT, SHALL be ignored.
REQ-021 key_load_i SHALL be honoured only in GATHER with count 0: it latches key_i into key_o and pulses invalid_cache_o exactly one cycle later. Otherwise it SHALL be ignored.
REQ-022 key_load_i on the same cycle as the first word transfer SHALL be honoured and apply to that block.
REQ-023 iv_load_i SHALL follow the same acceptance rule as key_load_i and SHALL NOT pulse invalid_cache_o.
REQ-024 Latency from ready_i handshake to first word_v_o SHALL be (engine latency + 1) cycles.

Reset
REQ-025 On reset_i=0, asynchronously: state GATHER, count 0, v_o/yumi_o/word_v_o/invalid_cache_o 0, word_ready_o 1 after release, and all data registers 0.
REQ-026 Reset mid-block SHALL discard the partial or in-flight block. A later v_i SHALL be ignored because the state is GATHER.

Configuration
REQ-027 With SM4_HOST_CBC_EN defined, the block SHALL keep chain register CR (loaded by iv_load_i):
- Encrypt: content_o = gathered ^ CR; CR <= crypt_i.
- Decrypt: content_o = gathered; output = crypt_i ^ CR; CR <= gathered.
REQ-028 Without SM4_HOST_CBC_EN, the block SHALL operate in ECB mode. iv_i and iv_load_i SHALL stay in the port list but be ignored, and no CR flops SHALL exist.

Verification
REQ-029 ECB encrypt:
- Stimulus: key 0123456789abcdeffedcba9876543210 loaded; words 01234567, 89abcdef, fedcba98, 76543210 with mode_i=1.
- Response: content_o=0123456789abcdeffedcba9876543210.
- Engine model returns 681edf34d206965e86b3e94f536e4246.
- word_o: 681edf34, d206965e, 86b3e94f, 536e4246.
REQ-030 Backpressure: ready_i low for 5 cycles in ISSUE -> v_o=1 and content_o unchanged for all 5; word_ready_o=0.
REQ-031 Host stall: word_yumi_i low for 3 cycles on word 2 -> word_o holds d206965e; no word is lost or duplicated.
REQ-032 Key load at count 0 -> invalid_cache_o high exactly 1 cycle. Key load at count 2 -> key_o unchanged and no pulse.
REQ-033 reset_i=0 while in WAIT -> v_o, yumi_o and word_v_o are 0 immediately; v_i=1 after release yields yumi_o=0.
REQ-034 CBC (macro defined):
- Stimulus: IV 0; two identical plaintext blocks P.
- Response: second content_o = P ^ 681edf34d206965e86b3e94f536e4246.
- Decrypting the two ciphertexts restores P twice.

Source files
------------

// File: rtl/sm4_encryptor_host.sv
// rtl/sm4_encryptor_host.sv - SM4 host word adapter: gathers 4 words, issues one block, drains 4 words.
// Optional CBC chaining is enabled by defining SM4_HOST_CBC_EN; the default build is ECB.
module sm4_encryptor_host #(
  parameter int BYTE_SWAP = 0
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic [31:0]  word_i,
  input  logic         word_v_i,
  output logic         word_ready_o,
  input  logic         mode_i,
  input  logic [127:0] key_i,
  input  logic         key_load_i,
  input  logic [127:0] iv_i,
  input  logic         iv_load_i,
  output logic [127:0] content_o,
  output logic [127:0] key_o,
  output logic         encode_or_decode_o,
  output logic         v_o,
  input  logic         ready_i,
  input  logic [127:0] crypt_i,
  input  logic         v_i,
  output logic         yumi_o,
  output logic         invalid_cache_o,
  output logic [31:0]  word_o,
  output logic         word_v_o,
  input  logic         word_yumi_i
);

  typedef enum logic [1:0] {
    S_GATHER = 2'd0,
    S_ISSUE  = 2'd1,
    S_WAIT   = 2'd2,
    S_DRAIN  = 2'd3
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [1:0]    cnt;
  logic [127:0]  blk_q;
  logic [127:0]  res_q;
  logic [127:0]  key_q;
  logic          mode_q;
  logic          inv_q;
  logic          word_fire;
  logic          out_fire;
  logic          load_ok;
  logic [127:0]  result_in;

  function automatic logic [31:0] swap32(input logic [31:0] w);
    swap32 = (BYTE_SWAP != 0) ? {w[7:0], w[15:8], w[23:16], w[31:24]} : w;
  endfunction

  assign word_fire = word_v_i & word_ready_o;
  assign out_fire  = word_v_o & word_yumi_i;
  // Key/IV loads only land between blocks, before the first word is taken.
  assign load_ok   = (state == S_GATHER) && (cnt == 2'd0);

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state <= S_GATHER;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_GATHER: if (word_fire && (cnt == 2'd3)) state_nxt = S_ISSUE;
      S_ISSUE:  if (ready_i) state_nxt = S_WAIT;
      S_WAIT:   if (v_i) state_nxt = S_DRAIN;
      S_DRAIN:  if (word_yumi_i && (cnt == 2'd3)) state_nxt = S_GATHER;
      default:  state_nxt = S_GATHER;
    endcase
  end

  always_comb begin
    word_ready_o = 1'b0;
    v_o          = 1'b0;
    word_v_o     = 1'b0;
    yumi_o       = 1'b0;
    case (state)
      S_GATHER: word_ready_o = 1'b1;
      S_ISSUE:  v_o = 1'b1;
      S_WAIT:   yumi_o = v_i;
      S_DRAIN:  word_v_o = 1'b1;
      default:  word_ready_o = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      cnt    <= 2'd0;
      blk_q  <= '0;
      res_q  <= '0;
      key_q  <= '0;
      mode_q <= 1'b0;
      inv_q  <= 1'b0;
    end else begin
      inv_q <= load_ok & key_load_i;
      if (load_ok && key_load_i) begin
        key_q <= key_i;
      end
      if (word_fire || out_fire) begin
        cnt <= cnt + 2'd1;
      end
      if (word_fire) begin
        blk_q <= {blk_q[95:0], swap32(word_i)};
        if (cnt == 2'd0) begin
          mode_q <= mode_i;
        end
      end
      if (yumi_o) begin
        res_q <= result_in;
      end else if (out_fire) begin
        res_q <= {res_q[95:0], 32'h0};
      end
    end
  end

`ifdef SM4_HOST_CBC_EN
  logic [127:0] cr_q;

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      cr_q <= '0;
    end else if (load_ok && iv_load_i) begin
      cr_q <= iv_i;
    end else if (yumi_o) begin
      // Encrypt chains on the ciphertext produced; decrypt chains on the ciphertext consumed.
      cr_q <= mode_q ? crypt_i : blk_q;
    end
  end

  assign content_o = mode_q ? (blk_q ^ cr_q) : blk_q;
  assign result_in = mode_q ? crypt_i : (crypt_i ^ cr_q);
`else
  logic unused_iv;

  assign unused_iv = ^{iv_i, iv_load_i};
  assign content_o = blk_q;
  assign result_in = crypt_i;
`endif

  assign key_o              = key_q;
  assign encode_or_decode_o = mode_q;
  assign invalid_cache_o    = inv_q;
  assign word_o             = swap32(res_q[127:96]);

endmodule

// File: tb/tb_sm4_encryptor_host.sv
// tb/tb_sm4_encryptor_host.sv - directed bench for sm4_encryptor_host (CBC steps when SM4_HOST_CBC_EN is defined).
module tb_sm4_encryptor_host;

  logic         clk_i = 1'b0;
  logic         reset_i;
  logic [31:0]  word_i;
  logic         word_v_i;
  logic         word_ready_o;
  logic         mode_i;
  logic [127:0] key_i;
  logic         key_load_i;
  logic [127:0] iv_i;
  logic         iv_load_i;
  logic [127:0] content_o;
  logic [127:0] key_o;
  logic         encode_or_decode_o;
  logic         v_o;
  logic         ready_i;
  logic [127:0] crypt_i;
  logic         v_i;
  logic         yumi_o;
  logic         invalid_cache_o;
  logic [31:0]  word_o;
  logic         word_v_o;
  logic         word_yumi_i;

  int errors = 0;
  int checks = 0;

  localparam logic [127:0] K  = 128'h0123456789abcdeffedcba9876543210;
  localparam logic [127:0] P  = 128'h0123456789abcdeffedcba9876543210;
  localparam logic [127:0] C  = 128'h681edf34d206965e86b3e94f536e4246;
  localparam logic [127:0] Q  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] K2 = 128'h0f0e0d0c0b0a09080706050403020100;
  localparam logic [127:0] K3 = 128'hffffffffffffffffffffffffffffffff;

  always #5 clk_i = ~clk_i;

  sm4_encryptor_host #(.BYTE_SWAP(0)) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .word_i(word_i), .word_v_i(word_v_i), .word_ready_o(word_ready_o),
    .mode_i(mode_i), .key_i(key_i), .key_load_i(key_load_i),
    .iv_i(iv_i), .iv_load_i(iv_load_i),
    .content_o(content_o), .key_o(key_o), .encode_or_decode_o(encode_or_decode_o),
    .v_o(v_o), .ready_i(ready_i), .crypt_i(crypt_i), .v_i(v_i), .yumi_o(yumi_o),
    .invalid_cache_o(invalid_cache_o), .word_o(word_o), .word_v_o(word_v_o),
    .word_yumi_i(word_yumi_i)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic nc();
    @(negedge clk_i);
  endtask

  task automatic send_word(input logic [31:0] w, input logic m);
    word_i   = w;
    mode_i   = m;
    word_v_i = 1'b1;
    nc();
    word_v_i = 1'b0;
  endtask

`ifdef SM4_HOST_CBC_EN
  // Engine stand-in: knows the reference SM4 pair, otherwise XORs with the key (self-inverse).
  function automatic logic [127:0] eng(input logic [127:0] x, input logic enc, input logic [127:0] k);
    if (enc && x == P) eng = C;
    else if (!enc && x == C) eng = P;
    else eng = x ^ k;
  endfunction

  task automatic run_block(input logic [127:0] blk, input logic m,
                           output logic [127:0] sent, output logic [127:0] got);
    for (int i = 0; i < 4; i++) send_word(blk[127-32*i -: 32], m);
    chk("cbc_v_o", {127'd0, v_o}, 128'd1);
    sent    = content_o;
    ready_i = 1'b1;
    nc();
    ready_i = 1'b0;
    nc();
    crypt_i = eng(sent, m, key_o);
    v_i     = 1'b1;
    nc();
    v_i     = 1'b0;
    got     = '0;
    for (int i = 0; i < 4; i++) begin
      chk("cbc_word_v_o", {127'd0, word_v_o}, 128'd1);
      got[127-32*i -: 32] = word_o;
      word_yumi_i = 1'b1;
      nc();
      word_yumi_i = 1'b0;
    end
  endtask
`endif

  initial begin
`ifdef SM4_HOST_CBC_EN
    logic [127:0] cont1, cont2, res1, res2, cdummy, d1, d2;
`endif
    reset_i = 1'b0; word_i = '0; word_v_i = 1'b0; mode_i = 1'b0;
    key_i = '0; key_load_i = 1'b0; iv_i = '0; iv_load_i = 1'b0;
    ready_i = 1'b0; crypt_i = '0; v_i = 1'b0; word_yumi_i = 1'b0;
    nc(); nc();
    chk("rst_v_o", {127'd0, v_o}, 128'd0);
    chk("rst_word_v_o", {127'd0, word_v_o}, 128'd0);
    chk("rst_invalid", {127'd0, invalid_cache_o}, 128'd0);
    reset_i = 1'b1;
    nc();
    chk("rst_word_ready", {127'd0, word_ready_o}, 128'd1);
    chk("rst_key_o", key_o, 128'd0);
    chk("rst_content_o", content_o, 128'd0);
    chk("rst_yumi", {127'd0, yumi_o}, 128'd0);

    // Key load at count 0: key lands, invalid_cache_o pulses for exactly one cycle.
    key_i = K; key_load_i = 1'b1;
    nc();
    key_load_i = 1'b0;
    chk("key_o_loaded", key_o, K);
    chk("inv_pulse_hi", {127'd0, invalid_cache_o}, 128'd1);
    nc();
    chk("inv_pulse_lo", {127'd0, invalid_cache_o}, 128'd0);

    // ECB encrypt with 5 cycles of engine backpressure.
    send_word(32'h01234567, 1'b1);
    send_word(32'h89abcdef, 1'b1);
    send_word(32'hfedcba98, 1'b1);
    send_word(32'h76543210, 1'b1);
    for (int i = 0; i < 5; i++) begin
      chk("issue_v_o", {127'd0, v_o}, 128'd1);
      chk("issue_content", content_o, P);
      chk("issue_word_ready", {127'd0, word_ready_o}, 128'd0);
      chk("issue_mode", {127'd0, encode_or_decode_o}, 128'd1);
      nc();
    end
    v_i = 1'b1;
    #1 chk("yumi_outside_wait", {127'd0, yumi_o}, 128'd0);
    nc();
    v_i = 1'b0;
    chk("still_issue", {127'd0, v_o}, 128'd1);
    ready_i = 1'b1;
    nc();
    ready_i = 1'b0;
    chk("wait_v_o", {127'd0, v_o}, 128'd0);
    chk("wait_word_v_o", {127'd0, word_v_o}, 128'd0);
    nc();
    chk("wait2_word_v_o", {127'd0, word_v_o}, 128'd0);
    crypt_i = C; v_i = 1'b1;
    #1 chk("wait_yumi", {127'd0, yumi_o}, 128'd1);
    nc();
    v_i = 1'b0; crypt_i = '0;
    chk("drain_word_v_o", {127'd0, word_v_o}, 128'd1);
    chk("drain_w0", {96'd0, word_o}, 128'h681edf34);
    chk("drain_yumi_o", {127'd0, yumi_o}, 128'd0);

    // Host stall on word 2.
    word_yumi_i = 1'b1;
    nc();
    word_yumi_i = 1'b0;
    chk("drain_w1", {96'd0, word_o}, 128'hd206965e);
    for (int i = 0; i < 3; i++) begin
      nc();
      chk("stall_w1", {96'd0, word_o}, 128'hd206965e);
      chk("stall_word_v_o", {127'd0, word_v_o}, 128'd1);
    end
    word_yumi_i = 1'b1;
    nc();
    chk("drain_w2", {96'd0, word_o}, 128'h86b3e94f);
    nc();
    chk("drain_w3", {96'd0, word_o}, 128'h536e4246);
    nc();
    word_yumi_i = 1'b0;
    chk("drain_done_v", {127'd0, word_v_o}, 128'd0);
    chk("back_to_gather", {127'd0, word_ready_o}, 128'd1);

    // Key load with the first word applies; key load at count 2 is dropped; stray word_yumi_i ignored.
    word_yumi_i = 1'b1;
    key_i = K2; key_load_i = 1'b1;
    send_word(32'h00112233, 1'b0);
    key_load_i = 1'b0;
    chk("key_with_first_word", key_o, K2);
    chk("inv_first_word", {127'd0, invalid_cache_o}, 128'd1);
    send_word(32'h44556677, 1'b0);
    word_yumi_i = 1'b0;
    key_i = K3; key_load_i = 1'b1;
    nc();
    key_load_i = 1'b0;
    chk("key_cnt2_ignored", key_o, K2);
    chk("inv_cnt2_none", {127'd0, invalid_cache_o}, 128'd0);
    send_word(32'h8899aabb, 1'b0);
    send_word(32'hccddeeff, 1'b0);
    chk("dec_v_o", {127'd0, v_o}, 128'd1);
    chk("dec_content", content_o, Q);
    chk("dec_mode", {127'd0, encode_or_decode_o}, 128'd0);
    ready_i = 1'b1;
    nc();
    ready_i = 1'b0;

    // Reset while in WAIT discards the block.
    v_i = 1'b1;
    #1 chk("pre_reset_yumi", {127'd0, yumi_o}, 128'd1);
    #1 reset_i = 1'b0;
    #1 chk("async_rst_yumi", {127'd0, yumi_o}, 128'd0);
    chk("async_rst_v_o", {127'd0, v_o}, 128'd0);
    chk("async_rst_word_v", {127'd0, word_v_o}, 128'd0);
    nc();
    reset_i = 1'b1;
    nc();
    chk("post_rst_yumi", {127'd0, yumi_o}, 128'd0);
    chk("post_rst_ready", {127'd0, word_ready_o}, 128'd1);
    chk("post_rst_key", key_o, 128'd0);
    chk("post_rst_word_v", {127'd0, word_v_o}, 128'd0);
    v_i = 1'b0;
    nc();

`ifdef SM4_HOST_CBC_EN
    key_i = K; key_load_i = 1'b1; iv_i = '0; iv_load_i = 1'b1;
    nc();
    key_load_i = 1'b0; iv_load_i = 1'b0;
    run_block(P, 1'b1, cont1, res1);
    run_block(P, 1'b1, cont2, res2);
    chk("cbc_content1", cont1, P);
    chk("cbc_cipher1", res1, C);
    chk("cbc_content2", cont2, P ^ C);
    iv_i = '0; iv_load_i = 1'b1;
    nc();
    iv_load_i = 1'b0;
    chk("cbc_iv_no_inv", {127'd0, invalid_cache_o}, 128'd0);
    run_block(res1, 1'b0, cdummy, d1);
    run_block(res2, 1'b0, cdummy, d2);
    chk("cbc_plain1", d1, P);
    chk("cbc_plain2", d2, P);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
